// File: rtl/tvc_mem_pkg.sv
// rtl/tvc_mem_pkg.sv - shared types and constants for the download/CPU SDRAM arbiter
package tvc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_ACC = 2'd1,
        ST_DN_ACC  = 2'd2
    } arb_state_t;

    localparam logic [7:0]  IDX_ROM = 8'd0;
    localparam logic [7:0]  IDX_CAS = 8'd1;

    localparam logic [23:0] DEF_ROM_BASE = 24'h000000;
    localparam logic [23:0] DEF_CAS_BASE = 24'h100000;
    localparam logic [24:0] DEF_ROM_SIZE = 25'h10000;

endpackage

// File: rtl/dl_byte_buf.sv
// rtl/dl_byte_buf.sv - one-entry download byte buffer with file-index to SDRAM address mapping
module dl_byte_buf
    import tvc_mem_pkg::*;
#(
    parameter logic [23:0] ROM_BASE = DEF_ROM_BASE,
    parameter logic [23:0] CAS_BASE = DEF_CAS_BASE,
    parameter logic [24:0] ROM_SIZE = DEF_ROM_SIZE
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        dn_wr,
    input  logic [24:0] dn_addr,
    input  logic [7:0]  dn_data,
    input  logic [7:0]  dn_idx,
    input  logic        pop,
    output logic        full,
    output logic        pending,
    output logic [23:0] map_addr,
    output logic [7:0]  map_data,
    output logic        overrun
);

    logic [24:0] buf_addr;
    logic [7:0]  buf_data;
    logic [7:0]  buf_idx;
    logic        map_ok;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            full     <= 1'b0;
            overrun  <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
            buf_idx  <= '0;
        end else if (dn_wr && !full) begin
            full     <= 1'b1;
            buf_addr <= dn_addr;
            buf_data <= dn_data;
            buf_idx  <= dn_idx;
        end else begin
            // A strobe while full is lost, even in the cycle the entry drains.
            if (dn_wr)
                overrun <= 1'b1;
            if (pop || (full && !map_ok))
                full <= 1'b0;
        end
    end

    always_comb begin
        map_ok   = 1'b0;
        map_addr = '0;
        if (buf_idx == IDX_ROM && buf_addr < ROM_SIZE) begin
            map_ok   = 1'b1;
            map_addr = ROM_BASE + buf_addr[23:0];
        end else if (buf_idx == IDX_CAS) begin
            map_ok   = 1'b1;
            map_addr = CAS_BASE + buf_addr[23:0];
        end
    end

    assign pending  = full && map_ok;
    assign map_data = buf_data;

endmodule

// File: rtl/dl_mem_arbiter.sv
// rtl/dl_mem_arbiter.sv - round-robin SDRAM arbiter between CPU accesses and file download bytes
module dl_mem_arbiter
    import tvc_mem_pkg::*;
#(
    parameter logic [23:0] ROM_BASE = DEF_ROM_BASE,
    parameter logic [23:0] CAS_BASE = DEF_CAS_BASE,
    parameter logic [24:0] ROM_SIZE = DEF_ROM_SIZE
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        dn_go,
    input  logic        dn_wr,
    input  logic [24:0] dn_addr,
    input  logic [7:0]  dn_data,
    input  logic [7:0]  dn_idx,
    output logic        dn_clkref,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [23:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [23:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    input  logic        mem_ack,
    output logic        rom_loaded,
    output logic        dn_overrun
);

    arb_state_t  state_q, state_d;
    logic        last_cpu;
    logic        grant_cpu, grant_dn;
    logic        dn_pop, cpu_done;
    logic        buf_full, buf_pending;
    logic [23:0] buf_maddr;
    logic [7:0]  buf_mdata;
    logic        go_q, rom_pend;
    logic [7:0]  last_idx;

    dl_byte_buf #(
        .ROM_BASE (ROM_BASE),
        .CAS_BASE (CAS_BASE),
        .ROM_SIZE (ROM_SIZE)
    ) u_buf (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .dn_wr    (dn_wr),
        .dn_addr  (dn_addr),
        .dn_data  (dn_data),
        .dn_idx   (dn_idx),
        .pop      (dn_pop),
        .full     (buf_full),
        .pending  (buf_pending),
        .map_addr (buf_maddr),
        .map_data (buf_mdata),
        .overrun  (dn_overrun)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            last_cpu <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            cpu_ack  <= 1'b0;
            cpu_dout <= '0;
        end else begin
            state_q <= state_d;
            cpu_ack <= cpu_done;
            if (cpu_done)
                cpu_dout <= mem_dout;
            if (grant_cpu) begin
                mem_we   <= cpu_we;
                mem_addr <= cpu_addr;
                mem_din  <= cpu_din;
                last_cpu <= 1'b1;
            end else if (grant_dn) begin
                mem_we   <= 1'b1;
                mem_addr <= buf_maddr;
                mem_din  <= buf_mdata;
                last_cpu <= 1'b0;
            end
        end
    end

    // cpu_ack cycle is a dead cycle: the CPU is still dropping its request.
    always_comb begin
        state_d   = state_q;
        grant_cpu = 1'b0;
        grant_dn  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!cpu_ack) begin
                    if (cpu_req && buf_pending) begin
                        grant_dn  = last_cpu;
                        grant_cpu = !last_cpu;
                    end else begin
                        grant_cpu = cpu_req;
                        grant_dn  = buf_pending;
                    end
                end
                if (grant_cpu)
                    state_d = ST_CPU_ACC;
                else if (grant_dn)
                    state_d = ST_DN_ACC;
            end
            ST_CPU_ACC, ST_DN_ACC: begin
                if (mem_ack)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = (state_q != ST_IDLE);
        dn_pop    = (state_q == ST_DN_ACC) && mem_ack;
        cpu_done  = (state_q == ST_CPU_ACC) && mem_ack;
        dn_clkref = !buf_full;
    end

    // ROM completion waits for the final byte to be fully written back.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            go_q       <= 1'b0;
            last_idx   <= '0;
            rom_pend   <= 1'b0;
            rom_loaded <= 1'b0;
        end else begin
            go_q <= dn_go;
            if (dn_go)
                last_idx <= dn_idx;
            if (go_q && !dn_go && last_idx == IDX_ROM) begin
                rom_pend <= 1'b1;
            end else if (rom_pend && !buf_full && state_q != ST_DN_ACC) begin
                rom_pend   <= 1'b0;
                rom_loaded <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dl_mem_arbiter.sv
// tb/tb_dl_mem_arbiter.sv - directed and randomized bench for dl_mem_arbiter with SDRAM memory model
module tb_dl_mem_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        dn_go = 1'b0, dn_wr = 1'b0;
    logic [24:0] dn_addr = '0;
    logic [7:0]  dn_data = '0, dn_idx = '0;
    logic        dn_clkref;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [23:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic [7:0]  cpu_dout;
    logic        cpu_ack;
    logic        mem_req, mem_we;
    logic [23:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout = '0;
    logic        mem_ack = 1'b0;
    logic        rom_loaded, dn_overrun;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_m [logic [23:0]];
    logic [23:0] wq [$];
    logic [7:0]  idx_tab [6] = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd2, 8'd5};

    dl_mem_arbiter dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .dn_go      (dn_go),
        .dn_wr      (dn_wr),
        .dn_addr    (dn_addr),
        .dn_data    (dn_data),
        .dn_idx     (dn_idx),
        .dn_clkref  (dn_clkref),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .cpu_ack    (cpu_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mem_ack    (mem_ack),
        .rom_loaded (rom_loaded),
        .dn_overrun (dn_overrun)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; dn_go = 1'b0; dn_wr = 1'b0; cpu_req = 1'b0; mem_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic dn_drive(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        dn_wr = 1'b1; dn_idx = idx; dn_addr = a; dn_data = d;
    endtask

    task automatic cpu_drive(input logic we, input logic [23:0] a, input logic [7:0] d);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
    endtask

    // Reference address map: which SDRAM byte a download byte lands on, if any.
    task automatic model_map(input logic [7:0] idx, input logic [24:0] a,
                             output bit ok, output logic [23:0] ma);
        ok = 1'b0;
        ma = '0;
        if (idx == 8'd0 && a < 25'h10000) begin
            ok = 1'b1; ma = a[23:0];
        end else if (idx == 8'd1) begin
            ok = 1'b1; ma = 24'h100000 + a[23:0];
        end
    endtask

    // Acts as the SDRAM: waits for the request, checks it, acks after lat cycles.
    task automatic serve(input logic exp_we, input logic [23:0] exp_addr, input logic [7:0] exp_din,
                         input logic [7:0] rd, input int lat, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            dn_wr = 1'b0;
            n++;
        end while (mem_req !== 1'b1 && n < 16);
        check({tag, " req"}, mem_req, 1);
        if (mem_req === 1'b1) begin
            check({tag, " addr"}, mem_addr, exp_addr);
            check({tag, " we"}, mem_we, exp_we);
            check({tag, " din"}, mem_din, exp_din);
            for (int i = 1; i < lat; i++) tick();
            check({tag, " hold"}, {mem_req, mem_addr}, {1'b1, exp_addr});
            mem_dout = rd;
            mem_ack  = 1'b1;
            tick();
            mem_ack  = 1'b0;
            check({tag, " drop"}, mem_req, 0);
        end
    endtask

    initial begin
        do_reset();
        check("rst clkref", dn_clkref, 1);
        check("rst mem_req", mem_req, 0);
        check("rst mem_we", mem_we, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_din", mem_din, 0);
        check("rst cpu_ack", cpu_ack, 0);
        check("rst cpu_dout", cpu_dout, 0);
        check("rst rom_loaded", rom_loaded, 0);
        check("rst overrun", dn_overrun, 0);

        // ROM download of two bytes, ack three cycles after request
        dn_go = 1'b1;
        dn_drive(8'd0, 25'h0, 8'hA5);
        tick(); dn_wr = 1'b0;
        check("dl0 clkref low", dn_clkref, 0);
        serve(1'b1, 24'h000000, 8'hA5, 8'h00, 3, "dl0");
        check("dl0 clkref back", dn_clkref, 1);
        dn_drive(8'd0, 25'h1, 8'h5A);
        tick(); dn_wr = 1'b0;
        check("dl1 clkref low", dn_clkref, 0);
        serve(1'b1, 24'h000001, 8'h5A, 8'h00, 3, "dl1");
        check("dl1 clkref back", dn_clkref, 1);
        check("rom not yet", rom_loaded, 0);
        dn_go = 1'b0;
        tick(); tick(); tick();
        check("rom loaded", rom_loaded, 1);

        // CAS index and an unmapped index
        dn_go = 1'b1;
        dn_drive(8'd1, 25'h10, 8'h33);
        serve(1'b1, 24'h100010, 8'h33, 8'h00, 2, "cas");
        dn_drive(8'd2, 25'h20, 8'h44);
        tick(); dn_wr = 1'b0;
        check("idx2 full", dn_clkref, 0);
        tick();
        check("idx2 drained", {mem_req, dn_clkref}, 2'b01);
        dn_go = 1'b0;
        tick();
        check("rom sticky", rom_loaded, 1);

        // CPU read
        cpu_drive(1'b0, 24'h000123, 8'h00);
        serve(1'b0, 24'h000123, 8'h00, 8'hC3, 2, "cpurd");
        check("cpurd ack", cpu_ack, 1);
        check("cpurd dout", cpu_dout, 8'hC3);
        cpu_req = 1'b0;
        tick();
        check("cpurd ack pulse", cpu_ack, 0);

        // Contention from reset: download wins first, then alternation
        do_reset();
        dn_go = 1'b1;
        dn_drive(8'd1, 25'h20, 8'h11);
        tick(); dn_wr = 1'b0;
        cpu_drive(1'b1, 24'h000400, 8'h77);
        serve(1'b1, 24'h100020, 8'h11, 8'h00, 2, "rr dn1");
        dn_drive(8'd1, 25'h21, 8'h22);
        serve(1'b1, 24'h000400, 8'h77, 8'h00, 2, "rr cpu1");
        check("rr cpu1 ack", cpu_ack, 1);
        cpu_req = 1'b0;
        tick();
        check("rr ack gap", mem_req, 0);
        cpu_drive(1'b1, 24'h000401, 8'h78);
        serve(1'b1, 24'h100021, 8'h22, 8'h00, 1, "rr dn2");
        serve(1'b1, 24'h000401, 8'h78, 8'h00, 1, "rr cpu2");
        cpu_req = 1'b0;
        tick();

        // Byte strobe in the same cycle as the download ack is lost
        do_reset();
        dn_go = 1'b1;
        dn_drive(8'd1, 25'h30, 8'h9C);
        tick(); dn_wr = 1'b0;
        tick();
        check("ackwr req", mem_req, 1);
        mem_ack = 1'b1;
        dn_drive(8'd1, 25'h31, 8'h9D);
        tick();
        mem_ack = 1'b0; dn_wr = 1'b0;
        check("ackwr overrun", dn_overrun, 1);
        check("ackwr empty", dn_clkref, 1);
        tick();
        check("ackwr no req", mem_req, 0);

        // Back-to-back strobes with a full buffer, then an out-of-range ROM byte
        do_reset();
        dn_go = 1'b1;
        dn_drive(8'd1, 25'h0, 8'h01);
        tick();
        check("ovr before", dn_overrun, 0);
        dn_drive(8'd1, 25'h1, 8'h02);
        serve(1'b1, 24'h100000, 8'h01, 8'h00, 2, "ovr first");
        check("ovr flag", dn_overrun, 1);
        tick();
        check("ovr second lost", mem_req, 0);
        dn_drive(8'd0, 25'h10000, 8'hEE);
        tick(); dn_wr = 1'b0;
        tick();
        check("rom limit drop", {mem_req, dn_clkref}, 2'b01);
        dn_go = 1'b0;

        // Reset in the middle of a CPU access
        do_reset();
        cpu_drive(1'b1, 24'h00ABCD, 8'h5F);
        tick();
        check("rstmid req", mem_req, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0; cpu_req = 1'b0;
        mem_dout = 8'h99; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("rstmid ack", cpu_ack, 0);
        check("rstmid outs", {mem_req, mem_we, mem_addr, mem_din}, 0);
        check("rstmid dout", cpu_dout, 0);
        tick();
        check("rstmid later", {cpu_ack, mem_req, dn_clkref}, 3'b001);

        // Randomized traffic against the memory model
        dn_go = 1'b1;
        for (int it = 0; it < 40; it++) begin
            int          op, lat;
            bit          ok;
            logic [7:0]  idx, d, rd;
            logic [24:0] a;
            logic [23:0] ma;
            op  = int'($urandom_range(0, 2));
            lat = int'($urandom_range(1, 4));
            d   = 8'($urandom);
            if (op == 0) begin
                idx = idx_tab[$urandom_range(0, 5)];
                a   = (idx == 8'd0) ? 25'($urandom_range(0, 32'h1FFFF)) : 25'($urandom_range(0, 32'hFFFF));
                model_map(idx, a, ok, ma);
                dn_drive(idx, a, d);
                if (ok) begin
                    serve(1'b1, ma, d, 8'h00, lat, "rnd dl");
                    mem_m[ma] = d;
                    wq.push_back(ma);
                    check("rnd dl clkref", dn_clkref, 1);
                end else begin
                    tick(); dn_wr = 1'b0;
                    tick();
                    check("rnd dl drop", {mem_req, dn_clkref}, 2'b01);
                end
            end else begin
                if (wq.size() > 0 && $urandom_range(0, 3) != 0)
                    ma = wq[$urandom_range(0, wq.size() - 1)];
                else
                    ma = 24'($urandom_range(0, 32'hFFFF));
                if (op == 1) begin
                    cpu_drive(1'b1, ma, d);
                    serve(1'b1, ma, d, 8'h00, lat, "rnd cpuwr");
                    mem_m[ma] = d;
                    if (!(ma inside {wq})) wq.push_back(ma);
                    check("rnd cpuwr ack", cpu_ack, 1);
                end else begin
                    rd = mem_m.exists(ma) ? mem_m[ma] : 8'($urandom);
                    cpu_drive(1'b0, ma, 8'h00);
                    serve(1'b0, ma, 8'h00, rd, lat, "rnd cpurd");
                    check("rnd cpurd ack", cpu_ack, 1);
                    check("rnd cpurd dout", cpu_dout, rd);
                end
                cpu_req = 1'b0;
                tick();
                check("rnd ack pulse", cpu_ack, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
